// File: rtl/vga_sync_gen_if.sv
// Signal bundle between the raster timing generator and its consumers
// (pixel generator and VGA sync pins).
interface vga_sync_gen_if ();
  logic        pixel_ce;
  logic [15:0] pixel_col;
  logic [15:0] pixel_row;
  logic        data_reset;
  logic        frame_start;
  logic        vga_hs;
  logic        vga_vs;
  logic        video_on;

  modport master (
    input  pixel_ce,
    output pixel_col,
    output pixel_row,
    output data_reset,
    output frame_start,
    output vga_hs,
    output vga_vs,
    output video_on
  );

  modport slave (
    output pixel_ce,
    input  pixel_col,
    input  pixel_row,
    input  data_reset,
    input  frame_start,
    input  vga_hs,
    input  vga_vs,
    input  video_on
  );
endinterface

// File: rtl/vga_sync_gen.sv
// Free-running 640x480@60 raster counters with sync/blank decode, delayed to
// line up with the pixel generator's registered colour output.
module vga_sync_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic           pixel_clk,
  input  logic           reset_n,
  vga_sync_gen_if.master bus
);
  localparam logic [15:0] H_LAST   = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [15:0] V_LAST   = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [15:0] H_VIS    = 16'(H_ACTIVE);
  localparam logic [15:0] V_VIS    = 16'(V_ACTIVE);
  localparam logic [15:0] HS_START = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_START = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);
  // Stage layout {hs, vs, on}; idle value is both syncs high, video off.
  localparam logic [2:0]  STAGE_IDLE = 3'b110;

  logic [15:0] r_col;
  logic [15:0] r_row;
  logic        r_data_reset;
  logic        r_frame_start;

  logic [15:0] w_col_next;
  logic [15:0] w_row_next;
  logic        w_col_wrap;
  logic        w_row_wrap;
  logic [2:0]  w_raw;
  logic [2:0]  w_tail;

  always_comb begin
    w_col_wrap = (r_col == H_LAST);
    w_row_wrap = (r_row == V_LAST);
    w_col_next = w_col_wrap ? 16'd0 : r_col + 16'd1;
    w_row_next = r_row;
    if (w_col_wrap) begin
      w_row_next = w_row_wrap ? 16'd0 : r_row + 16'd1;
    end
  end

  // Flags are decoded from the next counts so they match the counters they
  // are presented alongside.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col         <= '0;
      r_row         <= '0;
      r_data_reset  <= 1'b1;
      r_frame_start <= 1'b0;
    end else if (bus.pixel_ce) begin
      r_col         <= w_col_next;
      r_row         <= w_row_next;
      r_data_reset  <= (w_row_next >= V_VIS);
      r_frame_start <= w_col_wrap && w_row_wrap;
    end
  end

  assign w_raw[2] = !((r_col >= HS_START) && (r_col < HS_END));
  assign w_raw[1] = !((r_row >= VS_START) && (r_row < VS_END));
  assign w_raw[0] = (r_col < H_VIS) && (r_row < V_VIS);

  generate
    for (genvar gi = 0; gi < PIPE_DELAY; gi++) begin : g_stage
      logic [2:0] r_stage;
      logic [2:0] w_stage_in;

      if (gi == 0) begin : g_head
        assign w_stage_in = w_raw;
      end else begin : g_link
        assign w_stage_in = g_stage[gi-1].r_stage;
      end

      always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
          r_stage <= STAGE_IDLE;
        end else if (bus.pixel_ce) begin
          r_stage <= w_stage_in;
        end
      end
    end
  endgenerate

  assign w_tail = g_stage[PIPE_DELAY-1].r_stage;

  assign bus.pixel_col   = r_col;
  assign bus.pixel_row   = r_row;
  assign bus.data_reset  = r_data_reset;
  assign bus.frame_start = r_frame_start;
  assign bus.vga_hs      = w_tail[2];
  assign bus.vga_vs      = w_tail[1];
  assign bus.video_on    = w_tail[0];
endmodule
